// File: rtl/video_pkg.sv
// Shared types and colour constants for the video test-pattern generator.
package video_pkg;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    RAMP    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } pattern_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  localparam logic [9:0]  C_MAX     = 10'd1023;
  localparam logic [9:0]  C_MIN     = 10'd0;
  localparam logic [29:0] RGB_WHITE = {C_MAX, C_MAX, C_MAX};
  localparam logic [29:0] RGB_BLACK = {C_MIN, C_MIN, C_MIN};

  // Standard eight-bar sequence, left to right: W Y C G M R B K.
  function automatic logic [29:0] bar_rgb(input logic [2:0] idx);
    logic [29:0] rgb;
    case (idx)
      3'd0:    rgb = {C_MAX, C_MAX, C_MAX};
      3'd1:    rgb = {C_MAX, C_MAX, C_MIN};
      3'd2:    rgb = {C_MIN, C_MAX, C_MAX};
      3'd3:    rgb = {C_MIN, C_MAX, C_MIN};
      3'd4:    rgb = {C_MAX, C_MIN, C_MAX};
      3'd5:    rgb = {C_MAX, C_MIN, C_MIN};
      3'd6:    rgb = {C_MIN, C_MIN, C_MAX};
      default: rgb = {C_MIN, C_MIN, C_MIN};
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/pattern_color.sv
// Combinational pixel colour for the selected test pattern at (h_cnt, v_cnt).
module pattern_color
  import video_pkg::*;
#(
  parameter int HACT = 10,
  parameter int CHK  = 2
) (
  input  logic [11:0] h_cnt_i,
  input  logic [11:0] v_cnt_i,
  input  logic [9:0]  frame_cnt_i,
  input  pattern_t    pat_i,
  input  logic [29:0] solid_rgb_i,
  output logic [29:0] rgb_o
);

  localparam int CHK_LOG = $clog2(CHK);

  logic [14:0] bar_num;
  logic [2:0]  bar_idx;
  logic        chk_odd;
  logic        unused_v;

  assign bar_num  = {h_cnt_i, 3'b000};
  assign bar_idx  = 3'(bar_num / 15'(HACT));
  // CHK is a power of two, so the cell parity is a single counter bit.
  assign chk_odd  = h_cnt_i[CHK_LOG] ^ v_cnt_i[CHK_LOG];
  assign unused_v = ^v_cnt_i;

  always_comb begin
    rgb_o = RGB_BLACK;
    case (pat_i)
      BARS:    rgb_o = bar_rgb(bar_idx);
      RAMP:    rgb_o = {h_cnt_i[9:0], v_cnt_i[9:0], frame_cnt_i};
      CHECKER: rgb_o = chk_odd ? RGB_BLACK : RGB_WHITE;
      SOLID:   rgb_o = solid_rgb_i;
      default: rgb_o = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing generator with run control and registered sync/DE/RGB outputs.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int HACT = 10,
  parameter int HFP  = 2,
  parameter int HSW  = 2,
  parameter int HBP  = 2,
  parameter int VACT = 4,
  parameter int VFP  = 1,
  parameter int VSW  = 1,
  parameter int VBP  = 1,
  parameter int CHK  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_en,
  input  logic [1:0]  i_pat_sel,
  input  logic [29:0] i_solid_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [9:0]  o_r_data,
  output logic [9:0]  o_g_data,
  output logic [9:0]  o_b_data,
  output logic        o_frame_start
);

  localparam int HTOTAL = HACT + HFP + HSW + HBP;
  localparam int VTOTAL = VACT + VFP + VSW + VBP;

  localparam logic [11:0] H_ACT    = 12'(HACT);
  localparam logic [11:0] H_SYNC_S = 12'(HACT + HFP);
  localparam logic [11:0] H_SYNC_E = 12'(HACT + HFP + HSW);
  localparam logic [11:0] H_LAST   = 12'(HTOTAL - 1);
  localparam logic [11:0] V_ACT    = 12'(VACT);
  localparam logic [11:0] V_SYNC_S = 12'(VACT + VFP);
  localparam logic [11:0] V_SYNC_E = 12'(VACT + VFP + VSW);
  localparam logic [11:0] V_LAST   = 12'(VTOTAL - 1);

  run_state_t  state_q;
  logic [11:0] h_q, v_q;
  logic [9:0]  fcnt_q;
  pattern_t    pat_q;
  logic [29:0] solid_q;
  logic        hsync_q, vsync_q, de_q, fstart_q;
  logic [29:0] rgb_q;

  logic        frame_top_d, de_d, hsync_d, vsync_d;
  logic        h_last_d, v_last_d;
  pattern_t    pat_d;
  logic [29:0] solid_d, pix_rgb_d;

  // The first pixel of a frame already uses the freshly latched selection.
  assign frame_top_d = (h_q == 12'd0) && (v_q == 12'd0);
  assign pat_d       = frame_top_d ? pattern_t'(i_pat_sel) : pat_q;
  assign solid_d     = frame_top_d ? i_solid_rgb : solid_q;
  assign de_d        = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_d     = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
  assign vsync_d     = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
  assign h_last_d    = (h_q == H_LAST);
  assign v_last_d    = (v_q == V_LAST);

  pattern_color #(
    .HACT(HACT),
    .CHK (CHK)
  ) u_color (
    .h_cnt_i    (h_q),
    .v_cnt_i    (v_q),
    .frame_cnt_i(fcnt_q),
    .pat_i      (pat_d),
    .solid_rgb_i(solid_d),
    .rgb_o      (pix_rgb_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      h_q      <= 12'd0;
      v_q      <= 12'd0;
      fcnt_q   <= 10'd0;
      pat_q    <= BARS;
      solid_q  <= RGB_BLACK;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      rgb_q    <= RGB_BLACK;
      fstart_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hsync_q  <= 1'b1;
          vsync_q  <= 1'b1;
          de_q     <= 1'b0;
          rgb_q    <= RGB_BLACK;
          fstart_q <= 1'b0;
          // Start inside vertical sync so a vsync edge leads the first active line.
          if (i_en) begin
            state_q <= ST_RUN;
            h_q     <= 12'd0;
            v_q     <= V_SYNC_S;
          end
        end
        ST_RUN: begin
          hsync_q  <= hsync_d;
          vsync_q  <= vsync_d;
          de_q     <= de_d;
          rgb_q    <= de_d ? pix_rgb_d : RGB_BLACK;
          fstart_q <= frame_top_d;
          if (frame_top_d) begin
            pat_q   <= pat_d;
            solid_q <= solid_d;
            fcnt_q  <= fcnt_q + 10'd1;
          end
          if (h_last_d) begin
            h_q <= 12'd0;
            if (v_last_d) begin
              v_q <= 12'd0;
              if (!i_en) state_q <= ST_IDLE;
            end else begin
              v_q <= v_q + 12'd1;
            end
          end else begin
            h_q <= h_q + 12'd1;
          end
        end
      endcase
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_de          = de_q;
  assign o_r_data      = rgb_q[29:20];
  assign o_g_data      = rgb_q[19:10];
  assign o_b_data      = rgb_q[9:0];
  assign o_frame_start = fstart_q;

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter HACT, default 10: active pixels per line.
REQ-002 SHALL have parameters HFP/HSW/HBP, defaults 2/2/2: horizontal front porch, sync width and back porch, in clocks.
REQ-003 SHALL have parameter VACT, default 4: active lines per frame.
REQ-004 SHALL have parameters VFP/VSW/VBP, defaults 1/1/1: vertical front porch, sync width and back porch, in lines.
REQ-005 SHALL have parameter CHK, default 2: checker cell size in pixels; power of two.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port i_en, input, 1 bit: generator run enable.
REQ-009 SHALL have port i_pat_sel, input, 2 bits: pattern select (0 bars, 1 ramp, 2 checker, 3 solid).
REQ-010 SHALL have port i_solid_rgb, input, 30 bits: solid colour {R,G,B}.
REQ-011 SHALL have ports o_hsync and o_vsync, output, 1 bit each: active-low syncs.
REQ-012 SHALL have port o_de, output, 1 bit: active pixel valid.
REQ-013 SHALL have ports o_r_data, o_g_data and o_b_data, output, 10 bits each: pixel colour.
REQ-014 SHALL have port o_frame_start, output, 1 bit: single-cycle pulse at the first active pixel of each frame.

Function
REQ-015 SHALL hold h_cnt over 0..HTOTAL-1 and v_cnt over 0..VTOTAL-1. HTOTAL=HACT+HFP+HSW+HBP; VTOTAL=VACT+VFP+VSW+VBP; both counters 12 bits.
REQ-016 SHALL increment h_cnt every clock while enabled; at HTOTAL-1, h_cnt wraps to 0 and v_cnt increments. v_cnt wraps from VTOTAL-1 to 0.
REQ-017 SHALL order each line as: active (h<HACT), front porch, sync, back porch. Each frame follows the same order using v_cnt.
REQ-018 SHALL register every output; outputs reflect the counter state of the previous clock, giving one-cycle latency.
REQ-019 SHALL drive o_de=1 only when h_cnt<HACT and v_cnt<VACT, giving exactly HACT consecutive cycles per active line.
REQ-020 SHALL drive o_hsync=0 when HACT+HFP <= h_cnt < HACT+HFP+HSW, on every line including vertical blanking.
REQ-021 SHALL drive o_vsync=0 when VACT+VFP <= v_cnt < VACT+VFP+VSW; edges change only when h_cnt=0.
REQ-022 SHALL implement run-control states IDLE and RUN:
  - IDLE -> RUN when i_en=1. Counters load h=0, v=VACT+VFP, so a vsync falling edge precedes the first active line.
  - RUN -> IDLE when i_en=0 at h_cnt=HTOTAL-1 and v_cnt=VTOTAL-1; frames are never truncated.
REQ-023 SHALL hold o_hsync=1, o_vsync=1, o_de=0 and RGB=0 in IDLE.
REQ-024 SHALL latch i_pat_sel and i_solid_rgb at h=0,v=0. Mid-frame changes take effect only at the next frame.
REQ-025 SHALL generate colour bars (pattern 0) as follows:
  - Bar index = (h_cnt*8)/HACT, integer, 0..7.
  - Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Full channel = 1023, empty = 0.
REQ-026 SHALL generate the ramp (pattern 1) as R=h_cnt[9:0], G=v_cnt[9:0], B=frame counter [9:0]. The frame counter is 10 bits, increments at each frame start and wraps.
REQ-027 SHALL generate the checker (pattern 2) as white when ((h_cnt/CHK) xor (v_cnt/CHK)) bit0 = 0, else black.
REQ-028 SHALL output the latched i_solid_rgb for pattern 3.
REQ-029 SHALL force RGB=0 whenever o_de=0.
REQ-030 SHALL assert o_frame_start together with o_de for the pixel with h=0, v=0.

Reset
REQ-031 SHALL, while rstn=0, set: state IDLE; h_cnt=0; v_cnt=0; frame counter 0; latched pattern 0; latched colour 0; o_hsync=1; o_vsync=1; o_de=0; RGB=0; o_frame_start=0.
REQ-032 SHALL, on rstn assertion mid-line, return all outputs to reset values asynchronously with no partial line completed. After release, the generator restarts per REQ-022 if i_en=1.

Structure
REQ-033 SHALL place pattern_t (BARS, RAMP, CHECKER, SOLID) and 10-bit colour constants (C_MAX=1023, C_MIN=0) in a shared package video_pkg.
REQ-034 SHALL implement colour selection in one combinational sub-module, pattern_color, with inputs h_cnt, v_cnt, frame count, pattern and solid colour, and output a 30-bit RGB value.

Verification
REQ-035 SHALL cover enable from reset with default parameters (HTOTAL=16, VTOTAL=7) -> o_vsync falls before the first o_de, o_de high for 10 cycles × 4 lines per frame, and a period of 112 clocks per frame.
REQ-036 SHALL cover hsync timing -> o_hsync low exactly 2 cycles, starting 2 cycles after o_de falls; 7 hsync pulses per frame.
REQ-037 SHALL cover pattern 0 with HACT=8 -> pixel k has bar colour k, e.g. pixel 0 = {1023,1023,1023} and pixel 7 = {0,0,0}.
REQ-038 SHALL cover i_pat_sel changing 0->2 mid-frame -> the remaining pixels of that frame stay bars and the next frame is checker (CHK=2): pixel0 white, pixel2 black, and line1 pixel0 white.
REQ-039 SHALL cover i_en dropped mid-frame -> the frame completes and outputs go idle. It SHALL also cover rstn asserted mid-line -> o_de=0 and syncs=1 immediately.
REQ-040 SHALL cover pattern 1 across 1025 frames -> B increments by 1 per frame and wraps 1023->0.
